// File: rtl/rr_arbiter_8_decode.sv
// rr_arbiter_8_decode: round-robin arbiter for eight requesters.
//
// One requester at a time holds the resource. The winner is searched from the
// priority pointer upward with a 7->0 wrap. A grant is followed by one dead
// GAP cycle, so the one-hot grant vector is always zero for at least one cycle
// between two consecutive owners. The registered grant index and valid drive
// the 3-to-8 case decoder (dec3to8) that produces the one-hot grant.
//
// Optional feature, selected by the macro ARB_TIMEOUT_EN: a hold counter
// reclaims the resource after TIMEOUT grant cycles and pulses `timeout` for
// one cycle. Without the macro no counter is built, TIMEOUT is unused and
// `timeout` is tied low.
//
// Handshake contract: gnt_vld=1 means requester gnt_idx owns the resource in
// this cycle. The owner gives it back by pulsing done=1 or by dropping its
// req bit; either is sampled on the rising edge and gnt_vld is 0 after that
// edge. done is ignored whenever gnt_vld=0. gnt_idx keeps its last value
// while gnt_vld=0 and must always be qualified with gnt_vld.

module dec3to8 (
  input  logic [2:0] a,
  input  logic       en,
  output logic [7:0] y
);

  // One-hot decode of the index, all zeros while disabled.
  always_comb begin
    y = 8'd0;
    if (en) begin
      case (a)
        3'd0:    y = 8'b0000_0001;
        3'd1:    y = 8'b0000_0010;
        3'd2:    y = 8'b0000_0100;
        3'd3:    y = 8'b0000_1000;
        3'd4:    y = 8'b0001_0000;
        3'd5:    y = 8'b0010_0000;
        3'd6:    y = 8'b0100_0000;
        3'd7:    y = 8'b1000_0000;
        default: y = 8'd0;
      endcase
    end
  end

endmodule

module rr_arbiter_8_decode #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic [7:0] gnt,
  output logic       timeout,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] ptr;

  // Round-robin search results.
  logic       found;
  logic [2:0] winner;
  logic [2:0] cand;

  // Owner gives the resource back this cycle.
  logic       release_c;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       hold_expire;
  logic       timeout_q;
`endif

  // First set request at or above ptr, wrapping 7->0; pointer slot wins ties.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // done and a dropped request are the same event; both together is one release.
  assign release_c = done || !req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
  // Counter reads TIMEOUT-1 during the last permitted grant cycle.
  assign hold_expire = (hold_cnt == 8'(TIMEOUT - 1));
`endif

  // Arbiter FSM: registered grant index/valid, pointer and optional hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx <= winner;
            gnt_vld <= 1'b1;
            state   <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (release_c) begin
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 3'd1;
            state   <= GAP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_expire) begin
            // Forced release; the pulse lands in the GAP cycle.
            gnt_vld   <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            state     <= GAP;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          gnt_vld <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT;
  assign timeout = 1'b0;
`endif

  assign dbg_state = state;

  dec3to8 u_dec (
    .a  (gnt_idx),
    .en (gnt_vld),
    .y  (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8_decode.sv
// Bench for rr_arbiter_8_decode: directed scenarios plus random traffic,
// each checked against a behavioural arbiter model kept in this file.

module tb_rr_arbiter_8_decode;

  localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic [7:0] gnt;
  logic       timeout;
  logic [1:0] dbg_state;

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_8_decode #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld),
    .gnt       (gnt),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // holder: owning requester or -1; cool: dead cycles left before arbitration;
  // held: cycles the current owner has held the resource.
  int m_holder = -1;
  int m_idx    = 0;
  int m_ptr    = 0;
  int m_cool   = 0;
  int m_held   = 0;
  bit m_to     = 1'b0;

  function automatic logic [7:0] m_gnt();
    return (m_holder >= 0) ? (8'd1 << m_idx) : 8'd0;
  endfunction

  task automatic model_step(input bit r, input logic [7:0] rq, input bit d);
    int w;
    if (r) begin
      m_holder = -1; m_idx = 0; m_ptr = 0; m_cool = 0; m_held = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_holder >= 0) begin
      if (d || !rq[m_holder]) begin
        m_ptr = (m_holder + 1) % 8; m_holder = -1; m_cool = 1;
      end else if (TO_ON && m_held == TO) begin
        m_ptr = (m_holder + 1) % 8; m_holder = -1; m_cool = 1; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && rq[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      if (w >= 0) begin
        m_holder = w; m_idx = w; m_held = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input logic [7:0] rq, input bit d);
    @(negedge clk);
    rst = r; req = rq; done = d;
    @(posedge clk);
    model_step(r, rq, d);
    cyc++;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b1);
    checks_total++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || timeout !== 1'b0)
      $display("FAIL reset_outputs: got gnt=%h vld=%b idx=%0d to=%b, want 00/0/0/0", gnt, gnt_vld, gnt_idx, timeout);
    else checks_passed++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0);
      checks_total++;
      if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0)
        $display("FAIL idle_no_req: cyc %0d got gnt=%h vld=%b idx=%0d, want 00/0/0", i, gnt, gnt_vld, gnt_idx);
      else checks_passed++;
    end
  endtask

  task automatic test_alternate();
    logic [7:0] exp_q[$];
    logic [7:0] prev;
    int vld_cycles;
    exp_q = '{8'h04, 8'h20, 8'h04};
    step(1'b1, 8'h00, 1'b0);
    prev = 8'h00;
    vld_cycles = 0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      step(1'b0, 8'h24, vld_cycles == 3);
      vld_cycles = gnt_vld ? vld_cycles + 1 : 0;
      checks_total++;
      if (gnt !== m_gnt())
        $display("FAIL alt_model: got %h want %h", gnt, m_gnt());
      else checks_passed++;
      checks_total++;
      if (prev != 8'h00 && gnt != 8'h00 && gnt != prev)
        $display("FAIL alt_no_gap: got %h right after %h, want 00 between", gnt, prev);
      else checks_passed++;
      if (prev == 8'h00 && gnt != 8'h00) begin
        checks_total++;
        if (gnt !== exp_q[0])
          $display("FAIL alt_order: got %h want %h", gnt, exp_q[0]);
        else checks_passed++;
        void'(exp_q.pop_front());
      end
      prev = gnt;
    end
    checks_total++;
    if (exp_q.size() != 0)
      $display("FAIL alt_budget: %0d grants missing, want 0", exp_q.size());
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int last_cyc;
    bit prev_vld;
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(k));
    exp_q.push_back(8'd0);
    step(1'b1, 8'h00, 1'b0);
    last_cyc = -1;
    prev_vld = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      step(1'b0, 8'hFF, 1'b1);
      checks_total++;
      if (gnt !== m_gnt() || gnt_vld !== (m_holder >= 0))
        $display("FAIL b2b_model: got %h/%b want %h/%b", gnt, gnt_vld, m_gnt(), m_holder >= 0);
      else checks_passed++;
      if (gnt_vld && !prev_vld) begin
        checks_total++;
        if ({5'd0, gnt_idx} !== exp_q[0])
          $display("FAIL b2b_order: got idx %0d want %0d", gnt_idx, exp_q[0]);
        else checks_passed++;
        void'(exp_q.pop_front());
        if (last_cyc >= 0) begin
          checks_total++;
          if (cyc - last_cyc != 3)
            $display("FAIL b2b_spacing: got %0d cycles want 3", cyc - last_cyc);
          else checks_passed++;
        end
        last_cyc = cyc;
      end
      prev_vld = gnt_vld;
    end
    checks_total++;
    if (exp_q.size() != 0)
      $display("FAIL b2b_budget: %0d grants missing, want 0", exp_q.size());
    else checks_passed++;
  endtask

  task automatic test_wrap();
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h20, 1'b0);
    checks_total++;
    if (gnt !== 8'h20) $display("FAIL wrap_grant5: got %h want 20", gnt);
    else checks_passed++;
    step(1'b0, 8'h01, 1'b0);
    checks_total++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0) $display("FAIL wrap_drop: got %h/%b want 00/0", gnt, gnt_vld);
    else checks_passed++;
    step(1'b0, 8'h21, 1'b0);
    checks_total++;
    if (gnt !== 8'h00) $display("FAIL wrap_gap: got %h want 00", gnt);
    else checks_passed++;
    step(1'b0, 8'h21, 1'b0);
    checks_total++;
    if (gnt !== 8'h01) $display("FAIL wrap_next: got %h want 01", gnt);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_grant();
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h08, 1'b0);
    checks_total++;
    if (gnt !== 8'h08) $display("FAIL rmid_grant: got %h want 08", gnt);
    else checks_passed++;
    step(1'b1, 8'h08, 1'b0);
    checks_total++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || timeout !== 1'b0)
      $display("FAIL rmid_reset: got %h/%b/%b want 00/0/0", gnt, gnt_vld, timeout);
    else checks_passed++;
    step(1'b0, 8'h09, 1'b0);
    checks_total++;
    if (gnt !== 8'h01) $display("FAIL rmid_ptr: got %h want 01", gnt);
    else checks_passed++;
  endtask

  task automatic test_timeout();
    int run_len;
    int pulses;
    int runs;
    step(1'b1, 8'h00, 1'b0);
    run_len = 0; pulses = 0; runs = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 8'h02, 1'b0);
      checks_total++;
      if (gnt !== m_gnt() || timeout !== m_to)
        $display("FAIL to_model: got %h/%b want %h/%b", gnt, timeout, m_gnt(), m_to);
      else checks_passed++;
      if (timeout) pulses++;
      if (TO_ON) begin
        if (gnt == 8'h02) run_len++;
        else if (run_len > 0) begin
          runs++;
          checks_total++;
          if (run_len != TO) $display("FAIL to_length: got %0d want %0d", run_len, TO);
          else checks_passed++;
          run_len = 0;
        end
      end else begin
        checks_total++;
        if (gnt !== 8'h02 || timeout !== 1'b0)
          $display("FAIL to_hold: got %h/%b want 02/0", gnt, timeout);
        else checks_passed++;
      end
    end
    checks_total++;
    if (pulses != (TO_ON ? 4 : 0))
      $display("FAIL to_pulses: got %0d want %0d", pulses, TO_ON ? 4 : 0);
    else checks_passed++;
  endtask

  task automatic test_random();
    logic [7:0] rq;
    bit d, r;
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 500; i++) begin
      rq = 8'($urandom) & 8'($urandom);
      d  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(r, rq, d);
      checks_total++;
      if (gnt !== m_gnt() || gnt_vld !== (m_holder >= 0) ||
          gnt_idx !== 3'(m_idx) || timeout !== m_to)
        $display("FAIL rand_model: cyc %0d got gnt=%h vld=%b idx=%0d to=%b want %h/%b/%0d/%b",
                 i, gnt, gnt_vld, gnt_idx, timeout, m_gnt(), m_holder >= 0, m_idx, m_to);
      else checks_passed++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    test_reset();
    test_alternate();
    test_back_to_back();
    test_wrap();
    test_reset_mid_grant();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
